// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions: B response codes, index-width helper, BID field extract.
`ifndef AXI_IC_PKG_SV
`define AXI_IC_PKG_SV

`define AXI_BID_MST(bid, id_w, idx_w) bid[(id_w)-1 -: (idx_w)]

package axi_ic_pkg;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;

  // A one-entry index still needs a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/axi_bresp_router_if.sv
// B-channel bundle between downstream slaves, the router and upstream masters.
interface axi_bresp_router_if
  import axi_ic_pkg::*;
#(
  parameter int NUM_MST   = 4,
  parameter int NUM_SLV   = 4,
  parameter int TXN_ID_W  = 4,
  parameter int OUTST_MAX = 15
) ();
  localparam int MST_IDX_W = clog2_min1(NUM_MST);
  localparam int ID_W      = MST_IDX_W + TXN_ID_W;
  localparam int CNT_W     = $clog2(OUTST_MAX + 1);

  logic                         aw_issue;
  logic [MST_IDX_W-1:0]         aw_issue_mst;
  logic [NUM_SLV*ID_W-1:0]      M_AXI_bid;
  logic [NUM_SLV*2-1:0]         M_AXI_bresp;
  logic [NUM_SLV-1:0]           M_AXI_bvalid;
  logic [NUM_SLV-1:0]           M_AXI_bready;
  logic [NUM_MST*TXN_ID_W-1:0]  S_AXI_bid;
  logic [NUM_MST*2-1:0]         S_AXI_bresp;
  logic [NUM_MST-1:0]           S_AXI_bvalid;
  logic [NUM_MST-1:0]           S_AXI_bready;
  logic [NUM_MST*CNT_W-1:0]     outst_cnt;
  logic                         err_unexp;
  logic                         err_ovf;

  // Router side.
  modport slave (
    input  aw_issue, aw_issue_mst, M_AXI_bid, M_AXI_bresp, M_AXI_bvalid, S_AXI_bready,
    output M_AXI_bready, S_AXI_bid, S_AXI_bresp, S_AXI_bvalid, outst_cnt, err_unexp, err_ovf
  );

  // Environment side (slaves, masters, AW path).
  modport master (
    output aw_issue, aw_issue_mst, M_AXI_bid, M_AXI_bresp, M_AXI_bvalid, S_AXI_bready,
    input  M_AXI_bready, S_AXI_bid, S_AXI_bresp, S_AXI_bvalid, outst_cnt, err_unexp, err_ovf
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from a rotating pointer.
// Pointer moves just past the winner only on cycles where advance is asserted.
module rr_arbiter
  import axi_ic_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx
);
  logic [IDX_W-1:0] ptr;
  logic             found;

  function automatic int wrap(input int a);
    return (a >= N) ? a - N : a;
  endfunction

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap(int'(ptr) + i)]) begin
        found                                 = 1'b1;
        grant_onehot[wrap(int'(ptr) + i)]     = 1'b1;
        grant_idx                             = IDX_W'(wrap(int'(ptr) + i));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (advance)
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
  end
endmodule

// File: rtl/axi_bresp_router.sv
// Routes downstream B responses to upstream masters by BID master field; 1-cycle latency.
// A slave is only offered bready when its target master register can accept, so stalls stay local.
module axi_bresp_router
  import axi_ic_pkg::*;
#(
  parameter int NUM_MST   = 4,
  parameter int NUM_SLV   = 4,
  parameter int TXN_ID_W  = 4,
  parameter int OUTST_MAX = 15
) (
  input logic              ACLK,
  input logic              ARESET,
  axi_bresp_router_if.slave bus
);
  localparam int MST_IDX_W = clog2_min1(NUM_MST);
  localparam int ID_W      = MST_IDX_W + TXN_ID_W;
  localparam int CNT_W     = $clog2(OUTST_MAX + 1);
  localparam int SLV_IDX_W = clog2_min1(NUM_SLV);
  localparam int MST_SPAN  = 1 << MST_IDX_W;

  logic [ID_W-1:0]      slv_bid  [NUM_SLV];
  logic [MST_IDX_W-1:0] slv_dest [NUM_SLV];
  logic [MST_SPAN-1:0]  free_ext;
  logic [NUM_SLV-1:0]   eligible;
  logic [NUM_SLV-1:0]   grant;
  logic [SLV_IDX_W-1:0] grant_idx;
  logic                 hs;
  logic [MST_IDX_W-1:0] g_dest;
  logic [TXN_ID_W-1:0]  g_txn;
  logic [1:0]           g_resp;
  logic                 g_oor;
  logic [NUM_MST-1:0]   out_vld;
  logic [NUM_MST-1:0]   inc;
  logic [NUM_MST-1:0]   dec;
  logic [NUM_MST-1:0]   ovf_hit;
  logic [NUM_MST-1:0]   unexp_hit;
  logic                 err_unexp_q;
  logic                 err_ovf_q;

  for (genvar k = 0; k < NUM_SLV; k++) begin : g_slv
    assign slv_bid[k]  = bus.M_AXI_bid[k*ID_W +: ID_W];
    assign slv_dest[k] = `AXI_BID_MST(slv_bid[k], ID_W, MST_IDX_W);
    assign eligible[k] = bus.M_AXI_bvalid[k] & free_ext[slv_dest[k]] & ~ARESET;
  end

  // Out-of-range master indices are always free: they are consumed and dropped.
  always_comb begin
    free_ext              = '1;
    free_ext[NUM_MST-1:0] = ~out_vld | bus.S_AXI_bready;
  end

  rr_arbiter #(.N(NUM_SLV)) u_arb (
    .clk          (ACLK),
    .rst          (ARESET),
    .req          (eligible),
    .advance      (hs),
    .grant_onehot (grant),
    .grant_idx    (grant_idx)
  );

  assign hs               = |grant;
  assign bus.M_AXI_bready = grant;
  assign g_dest           = slv_dest[grant_idx];
  assign g_txn            = slv_bid[grant_idx][TXN_ID_W-1:0];
  assign g_resp           = bus.M_AXI_bresp[grant_idx*2 +: 2];
  assign g_oor            = int'(g_dest) >= NUM_MST;

  for (genvar m = 0; m < NUM_MST; m++) begin : g_mst
    logic                vld_q;
    logic [TXN_ID_W-1:0] txn_q;
    logic [1:0]          resp_q;
    logic [CNT_W-1:0]    cnt_q;

    assign dec[m] = hs & (int'(g_dest) == m);
    assign inc[m] = bus.aw_issue & (int'(bus.aw_issue_mst) == m);

    // A reload takes priority over drain so back-to-back responses leave no bubble.
    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        vld_q  <= 1'b0;
        txn_q  <= '0;
        resp_q <= '0;
      end else if (dec[m]) begin
        vld_q  <= 1'b1;
        txn_q  <= g_txn;
        resp_q <= g_resp;
      end else if (bus.S_AXI_bready[m]) begin
        vld_q  <= 1'b0;
      end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)
        cnt_q <= '0;
      else if (inc[m] && !dec[m] && cnt_q != CNT_W'(OUTST_MAX))
        cnt_q <= cnt_q + 1'b1;
      else if (dec[m] && !inc[m] && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end

    assign ovf_hit[m]   = inc[m] & ~dec[m] & (cnt_q == CNT_W'(OUTST_MAX));
    assign unexp_hit[m] = dec[m] & ~inc[m] & (cnt_q == '0);

    assign out_vld[m]                                  = vld_q;
    assign bus.S_AXI_bid[m*TXN_ID_W +: TXN_ID_W]       = txn_q;
    assign bus.S_AXI_bresp[m*2 +: 2]                   = resp_q;
    assign bus.outst_cnt[m*CNT_W +: CNT_W]             = cnt_q;
  end

  assign bus.S_AXI_bvalid = out_vld;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_unexp_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      err_unexp_q <= (hs & g_oor) | (|unexp_hit);
      err_ovf_q   <= |ovf_hit;
    end
  end

  assign bus.err_unexp = err_unexp_q;
  assign bus.err_ovf   = err_ovf_q;
endmodule

// File: tb/tb_axi_bresp_router.sv
// Directed bench for axi_bresp_router: vector table plus hand sequences for reset, stall, overflow, decode error.
module tb_axi_bresp_router;
  import axi_ic_pkg::*;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axi_bresp_router_if #(.NUM_MST(4), .NUM_SLV(4), .TXN_ID_W(4), .OUTST_MAX(15)) bus ();
  axi_bresp_router_if #(.NUM_MST(3), .NUM_SLV(4), .TXN_ID_W(4), .OUTST_MAX(15)) bus3 ();

  axi_bresp_router #(.NUM_MST(4), .NUM_SLV(4), .TXN_ID_W(4), .OUTST_MAX(15)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus.slave));
  axi_bresp_router #(.NUM_MST(3), .NUM_SLV(4), .TXN_ID_W(4), .OUTST_MAX(15)) dut3 (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus3.slave));

  typedef struct packed {
    logic [3:0]  bvalid;
    logic [23:0] bid;
    logic [7:0]  bresp;
    logic [3:0]  sbready;
    logic        aw;
    logic [1:0]  awm;
    logic [3:0]  mbready;
    logic [3:0]  sbvalid;
    logic [15:0] sbid;
    logic [7:0]  sbresp;
    logic [15:0] cnt;
    logic        unexp;
    logic        ovf;
  } vec_t;

  vec_t tbl [0:31];
  int   n_vec = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [5:0] mkbid(input logic [1:0] mst, input logic [3:0] txn);
    return {mst, txn};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle();
    bus.aw_issue = 1'b0;      bus.aw_issue_mst = '0;
    bus.M_AXI_bvalid = '0;    bus.M_AXI_bid = '0;    bus.M_AXI_bresp = '0;
    bus.S_AXI_bready = 4'hF;
    bus3.aw_issue = 1'b0;     bus3.aw_issue_mst = '0;
    bus3.M_AXI_bvalid = '0;   bus3.M_AXI_bid = '0;   bus3.M_AXI_bresp = '0;
    bus3.S_AXI_bready = 3'h7;
  endtask

  task automatic do_reset();
    idle();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
  endtask

  task automatic add(input logic [3:0] bvalid, input logic [23:0] bid, input logic [7:0] bresp,
                     input logic [3:0] sbready, input logic aw, input logic [1:0] awm,
                     input logic [3:0] mbready, input logic [3:0] sbvalid, input logic [15:0] sbid,
                     input logic [7:0] sbresp, input logic [15:0] cnt, input logic unexp,
                     input logic ovf);
    tbl[n_vec] = {bvalid, bid, bresp, sbready, aw, awm, mbready, sbvalid, sbid, sbresp, cnt,
                  unexp, ovf};
    n_vec++;
  endtask

  logic [23:0] fair_bid;
  logic [23:0] m1_bid;

  initial begin
    ARESET = 1'b1;
    idle();
    step(); step();

    // Reset state, then reset asserted while master 1 holds a response.
    chk("rst sbvalid", 64'(bus.S_AXI_bvalid), 64'(0));
    chk("rst cnt", 64'(bus.outst_cnt), 64'(0));
    chk("rst mbready", 64'(bus.M_AXI_bready), 64'(0));
    chk("rst errs", 64'({bus.err_unexp, bus.err_ovf}), 64'(0));
    ARESET = 1'b0;
    bus.aw_issue = 1'b1; bus.aw_issue_mst = 2'd1;
    step();
    chk("t1 cnt after aw", 64'(bus.outst_cnt), 64'h0010);
    bus.aw_issue = 1'b0;
    bus.S_AXI_bready = 4'h0;
    bus.M_AXI_bvalid = 4'b0001;
    bus.M_AXI_bid = {18'd0, mkbid(2'd1, 4'd3)};
    bus.M_AXI_bresp = {6'd0, BRESP_SLVERR};
    #1;
    chk("t1 mbready", 64'(bus.M_AXI_bready), 64'b0001);
    step();
    chk("t1 sbvalid", 64'(bus.S_AXI_bvalid), 64'b0010);
    chk("t1 sbid", 64'(bus.S_AXI_bid), 64'h0030);
    chk("t1 sbresp", 64'(bus.S_AXI_bresp), 64'h08);
    ARESET = 1'b1;
    bus.M_AXI_bvalid = 4'b0101;
    bus.M_AXI_bid = {12'd0, mkbid(2'd0, 4'd8), 6'd0, mkbid(2'd0, 4'd6)};
    bus.M_AXI_bresp = '0;
    #1;
    chk("t1 async sbvalid", 64'(bus.S_AXI_bvalid), 64'(0));
    chk("t1 async sbid", 64'(bus.S_AXI_bid), 64'(0));
    chk("t1 async sbresp", 64'(bus.S_AXI_bresp), 64'(0));
    chk("t1 async cnt", 64'(bus.outst_cnt), 64'(0));
    chk("t1 async mbready", 64'(bus.M_AXI_bready), 64'(0));
    step(); step();
    chk("t1 held mbready", 64'(bus.M_AXI_bready), 64'(0));
    ARESET = 1'b0;
    #1;
    chk("t1 first grant", 64'(bus.M_AXI_bready), 64'b0001);
    step();
    chk("t1 post sbvalid", 64'(bus.S_AXI_bvalid), 64'b0001);
    chk("t1 post sbid", 64'(bus.S_AXI_bid), 64'h0006);
    chk("t1 dec at 0 unexp", 64'(bus.err_unexp), 64'(1));

    // Vector table: fairness on master 0, then counter walk on master 1.
    do_reset();
    fair_bid = {mkbid(2'd0, 4'd3), mkbid(2'd0, 4'd2), mkbid(2'd0, 4'd1), mkbid(2'd0, 4'd0)};
    m1_bid   = {18'd0, mkbid(2'd1, 4'd9)};
    for (int i = 0; i < 5; i++)
      add(4'h0, 24'h0, 8'h00, 4'hF, 1'b1, 2'd0, 4'h0, 4'h0, 16'h0, 8'h00, 16'(i + 1), 1'b0, 1'b0);
    add(4'hF, fair_bid, 8'hE4, 4'hF, 1'b0, 2'd0, 4'b0001, 4'b0001, 16'h0000, 8'h00, 16'h0004, 1'b0, 1'b0);
    add(4'hF, fair_bid, 8'hE4, 4'hF, 1'b0, 2'd0, 4'b0010, 4'b0001, 16'h0001, 8'h01, 16'h0003, 1'b0, 1'b0);
    add(4'hF, fair_bid, 8'hE4, 4'hF, 1'b0, 2'd0, 4'b0100, 4'b0001, 16'h0002, 8'h02, 16'h0002, 1'b0, 1'b0);
    add(4'hF, fair_bid, 8'hE4, 4'hF, 1'b0, 2'd0, 4'b1000, 4'b0001, 16'h0003, 8'h03, 16'h0001, 1'b0, 1'b0);
    add(4'hF, fair_bid, 8'hE4, 4'hF, 1'b0, 2'd0, 4'b0001, 4'b0001, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0);
    add(4'h0, 24'h0, 8'h00, 4'hF, 1'b0, 2'd0, 4'h0, 4'h0, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++)
      add(4'h0, 24'h0, 8'h00, 4'hF, 1'b1, 2'd1, 4'h0, 4'h0, 16'h0000, 8'h00, 16'(i * 16), 1'b0, 1'b0);
    add(4'h1, m1_bid, 8'h01, 4'hF, 1'b0, 2'd0, 4'b0001, 4'b0010, 16'h0090, 8'h04, 16'h0020, 1'b0, 1'b0);
    add(4'h1, m1_bid, 8'h01, 4'hF, 1'b0, 2'd0, 4'b0001, 4'b0010, 16'h0090, 8'h04, 16'h0010, 1'b0, 1'b0);
    add(4'h1, m1_bid, 8'h01, 4'hF, 1'b0, 2'd0, 4'b0001, 4'b0010, 16'h0090, 8'h04, 16'h0000, 1'b0, 1'b0);
    add(4'h1, m1_bid, 8'h01, 4'hF, 1'b0, 2'd0, 4'b0001, 4'b0010, 16'h0090, 8'h04, 16'h0000, 1'b1, 1'b0);
    add(4'h0, 24'h0, 8'h00, 4'hF, 1'b0, 2'd0, 4'h0, 4'h0, 16'h0090, 8'h04, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < n_vec; i++) begin
      bus.M_AXI_bvalid = tbl[i].bvalid;
      bus.M_AXI_bid    = tbl[i].bid;
      bus.M_AXI_bresp  = tbl[i].bresp;
      bus.S_AXI_bready = tbl[i].sbready;
      bus.aw_issue     = tbl[i].aw;
      bus.aw_issue_mst = tbl[i].awm;
      #1;
      chk($sformatf("v%0d mbready", i), 64'(bus.M_AXI_bready), 64'(tbl[i].mbready));
      step();
      chk($sformatf("v%0d sbvalid", i), 64'(bus.S_AXI_bvalid), 64'(tbl[i].sbvalid));
      chk($sformatf("v%0d sbid", i), 64'(bus.S_AXI_bid), 64'(tbl[i].sbid));
      chk($sformatf("v%0d sbresp", i), 64'(bus.S_AXI_bresp), 64'(tbl[i].sbresp));
      chk($sformatf("v%0d cnt", i), 64'(bus.outst_cnt), 64'(tbl[i].cnt));
      chk($sformatf("v%0d err_unexp", i), 64'(bus.err_unexp), 64'(tbl[i].unexp));
      chk($sformatf("v%0d err_ovf", i), 64'(bus.err_ovf), 64'(tbl[i].ovf));
    end

    // Stalled master 2 must not block a response for master 0.
    do_reset();
    bus.aw_issue = 1'b1; bus.aw_issue_mst = 2'd2; step(); step();
    bus.aw_issue_mst = 2'd0; step();
    bus.aw_issue = 1'b0;
    chk("t3 cnt", 64'(bus.outst_cnt), 64'h0201);
    bus.S_AXI_bready = 4'b1011;
    bus.M_AXI_bvalid = 4'b0010;
    bus.M_AXI_bid = {12'd0, mkbid(2'd2, 4'd4), 6'd0};
    #1;
    chk("t3 load mbready", 64'(bus.M_AXI_bready), 64'b0010);
    step();
    chk("t3 load sbvalid", 64'(bus.S_AXI_bvalid), 64'b0100);
    bus.M_AXI_bvalid = 4'b1010;
    bus.M_AXI_bid = {mkbid(2'd0, 4'd7), 6'd0, mkbid(2'd2, 4'd5), 6'd0};
    #1;
    chk("t3 bypass mbready", 64'(bus.M_AXI_bready), 64'b1000);
    step();
    chk("t3 bypass sbvalid", 64'(bus.S_AXI_bvalid), 64'b0101);
    chk("t3 bypass sbid", 64'(bus.S_AXI_bid), 64'h0407);
    bus.M_AXI_bvalid = 4'b0010;
    #1;
    chk("t3 wait mbready", 64'(bus.M_AXI_bready), 64'(0));
    step();
    chk("t3 hold sbvalid", 64'(bus.S_AXI_bvalid), 64'b0100);
    chk("t3 hold sbid2", 64'(bus.S_AXI_bid[11:8]), 64'd4);
    bus.S_AXI_bready = 4'hF;
    #1;
    chk("t3 drain mbready", 64'(bus.M_AXI_bready), 64'b0010);
    step();
    chk("t3 b2b sbvalid", 64'(bus.S_AXI_bvalid), 64'b0100);
    chk("t3 b2b sbid2", 64'(bus.S_AXI_bid[11:8]), 64'd5);
    bus.M_AXI_bvalid = 4'b0000;
    step();
    chk("t3 empty sbvalid", 64'(bus.S_AXI_bvalid), 64'(0));
    chk("t3 end cnt", 64'(bus.outst_cnt), 64'(0));
    chk("t3 no unexp", 64'(bus.err_unexp), 64'(0));

    // Saturation and same-cycle increment/decrement on master 0.
    do_reset();
    bus.aw_issue = 1'b1; bus.aw_issue_mst = 2'd0;
    for (int i = 0; i < 15; i++) step();
    chk("t5 cnt full", 64'(bus.outst_cnt), 64'h000F);
    chk("t5 no ovf yet", 64'(bus.err_ovf), 64'(0));
    step();
    chk("t5 ovf pulse", 64'(bus.err_ovf), 64'(1));
    chk("t5 cnt sat", 64'(bus.outst_cnt), 64'h000F);
    bus.aw_issue = 1'b0;
    step();
    chk("t5 ovf clear", 64'(bus.err_ovf), 64'(0));
    bus.aw_issue = 1'b1;
    bus.M_AXI_bvalid = 4'b0100;
    bus.M_AXI_bid = {6'd0, mkbid(2'd0, 4'd1), 12'd0};
    #1;
    chk("t5 both mbready", 64'(bus.M_AXI_bready), 64'b0100);
    step();
    chk("t5 both cnt", 64'(bus.outst_cnt), 64'h000F);
    chk("t5 both ovf", 64'(bus.err_ovf), 64'(0));
    chk("t5 both sbvalid", 64'(bus.S_AXI_bvalid), 64'b0001);
    bus.aw_issue = 1'b0;
    step();
    chk("t5 dec cnt", 64'(bus.outst_cnt), 64'h000E);
    bus.M_AXI_bvalid = 4'b0000;

    // Decode error on the 3-master instance: master field 3 is out of range.
    do_reset();
    bus3.M_AXI_bvalid = 4'b0001;
    bus3.M_AXI_bid = {18'd0, mkbid(2'd3, 4'd2)};
    #1;
    chk("t6 mbready", 64'(bus3.M_AXI_bready), 64'b0001);
    step();
    chk("t6 sbvalid", 64'(bus3.S_AXI_bvalid), 64'(0));
    chk("t6 unexp pulse", 64'(bus3.err_unexp), 64'(1));
    chk("t6 cnt", 64'(bus3.outst_cnt), 64'(0));
    bus3.M_AXI_bvalid = 4'b0000;
    step();
    chk("t6 unexp clear", 64'(bus3.err_unexp), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
